// File: rtl/limb_pkg.sv
// limb_pkg: shared widths and redirect encoding for the Limb fetch stage.
package limb_pkg;
    localparam int PC_W = 8;
    localparam int IR_W = 32;
    typedef enum logic [1:0] {RD_NONE, RD_BRANCH, RD_CALL, RD_RET} redirect_e;
endpackage

// File: rtl/limb_call_stack.sv
// limb_call_stack: LIFO of return addresses; push when full and pop when empty are ignored.
module limb_call_stack #(
    parameter int STACK_DEPTH = 16,
    parameter int PC_W = 8
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [PC_W-1:0]                din,
    output logic [PC_W-1:0]                dout,
    output logic [$clog2(STACK_DEPTH):0]   sp,
    output logic                           full,
    output logic                           empty
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int SP_W = AW + 1;
    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic [AW-1:0]   top_idx;
    assign full    = sp == SP_W'(STACK_DEPTH);
    assign empty   = sp == '0;
    assign top_idx = AW'(sp - 1'b1);
    assign dout    = mem[top_idx];
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sp <= '0;
        else if (pop && !empty)
            sp <= sp - 1'b1;
        else if (push && !full)
            sp <= sp + 1'b1;
    end
    // Entries are not reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push && !pop && !full)
            mem[sp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/limb_fetch.sv
// limb_fetch: Limb CPU fetch stage with PC, instruction register and hardware call stack.
module limb_fetch #(
    parameter int PC_W = limb_pkg::PC_W,
    parameter int IR_W = limb_pkg::IR_W,
    parameter int STACK_DEPTH = 16
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    output logic [PC_W-1:0]                rom_addr,
    input  logic [IR_W-1:0]                rom_data,
    output logic [IR_W-1:0]                ir,
    output logic [PC_W-1:0]                ir_pc,
    output logic                           ir_valid,
    input  logic                           branch_taken,
    input  logic                           call,
    input  logic                           ret,
    input  logic [PC_W-1:0]                branch_target,
    output logic [$clog2(STACK_DEPTH):0]   sp,
    output logic                           stack_overflow,
    output logic                           stack_underflow
);
    import limb_pkg::*;
    redirect_e       rd;
    logic [PC_W-1:0] pc, next_pc, link, dout;
    logic            push, pop, full, empty;
    assign rom_addr = pc;
    assign link     = ir_pc + 1'b1;
    // Redirects only act on a live, non-stalled instruction.
    assign rd = !(ir_valid && !stall) ? RD_NONE :
                ret                   ? RD_RET :
                call                  ? RD_CALL :
                branch_taken          ? RD_BRANCH : RD_NONE;
    assign push    = rd == RD_CALL;
    assign pop     = rd == RD_RET;
    assign next_pc = rd == RD_RET  ? (empty ? link : dout) :
                     rd == RD_NONE ? pc + 1'b1 : branch_target;
    limb_call_stack #(.STACK_DEPTH(STACK_DEPTH), .PC_W(PC_W)) u_stack (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(link),
        .dout(dout), .sp(sp), .full(full), .empty(empty)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc              <= '0;
            ir              <= '0;
            ir_pc           <= '0;
            ir_valid        <= 1'b0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else if (!stall) begin
            pc              <= next_pc;
            ir              <= rom_data;
            ir_pc           <= pc;
            ir_valid        <= rd == RD_NONE;
            stack_overflow  <= stack_overflow | (push & full);
            stack_underflow <= stack_underflow | (pop & empty);
        end
    end
endmodule

// File: tb/tb_limb_fetch.sv
// tb_limb_fetch: directed and random stimulus against a queue-based fetch model.
module tb_limb_fetch;
    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0;
    logic        branch_taken = 1'b0, call = 1'b0, ret = 1'b0;
    logic [7:0]  branch_target = '0, rom_addr, ir_pc;
    logic [31:0] rom_data, ir;
    logic        ir_valid, stack_overflow, stack_underflow;
    logic [4:0]  sp;
    int checks = 0, errors = 0;
    int m_pc, m_irpc, q[$];
    logic [31:0] m_ir;
    bit m_valid, m_ovf, m_unf;

    always #5 clk = ~clk;
    assign rom_data = 32'h1000_0000 + 32'(rom_addr);

    limb_fetch #(.PC_W(8), .IR_W(32), .STACK_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .rom_addr(rom_addr), .rom_data(rom_data),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .branch_taken(branch_taken),
        .call(call), .ret(ret), .branch_target(branch_target), .sp(sp),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("rom_addr", 32'(rom_addr), m_pc);
        check("ir", ir, m_ir);
        check("ir_pc", 32'(ir_pc), m_irpc);
        check("ir_valid", 32'(ir_valid), 32'(m_valid));
        check("sp", 32'(sp), q.size());
        check("overflow", 32'(stack_overflow), 32'(m_ovf));
        check("underflow", 32'(stack_underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        m_pc = 0; m_irpc = 0; m_ir = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
        q.delete();
    endtask

    task automatic tick();
        int  npc;
        bit  nv, live;
        live = m_valid && !stall;
        npc = (m_pc + 1) % 256;
        nv = 1;
        if (live && ret) begin
            nv = 0;
            if (q.size() == 0) begin
                m_unf = 1;
                npc = (m_irpc + 1) % 256;
            end else
                npc = q.pop_back();
        end else if (live && call) begin
            nv = 0;
            if (q.size() == 16) m_ovf = 1;
            else q.push_back((m_irpc + 1) % 256);
            npc = int'(branch_target);
        end else if (live && branch_taken) begin
            nv = 0;
            npc = int'(branch_target);
        end
        @(posedge clk);
        #1;
        if (!stall) begin
            m_ir = 32'h1000_0000 + 32'(m_pc);
            m_irpc = m_pc;
            m_valid = nv;
            m_pc = npc;
        end
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #2 reset = 1'b0;
    endtask

    task automatic run_to(input int a);
        int n = 0;
        while (!(m_valid && m_irpc == a) && n < 300) begin
            tick();
            n++;
        end
        check("run_to_reached", 32'(n < 300), 32'd1);
    endtask

    task automatic redirect(input bit is_call, input bit is_ret, input bit is_br, input logic [7:0] t);
        call = is_call; ret = is_ret; branch_taken = is_br; branch_target = t;
        tick();
        call = 0; ret = 0; branch_taken = 0;
        tick();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        #1 reset = 1'b0;
        repeat (260) tick();

        do_reset();
        run_to(5);
        redirect(0, 0, 1, 8'h40);
        tick();

        do_reset();
        run_to(8'h10);
        redirect(1, 0, 0, 8'h80);
        run_to(8'h82);
        redirect(0, 1, 0, 8'h00);
        tick();

        do_reset();
        tick();
        for (int i = 0; i < 17; i++) redirect(1, 0, 0, 8'($urandom));
        check("sp_saturated", 32'(sp), 32'd16);
        for (int i = 0; i < 17; i++) redirect(0, 1, 0, 8'($urandom));
        tick();

        stall = 1; branch_taken = 1; branch_target = 8'hAA;
        repeat (3) tick();
        stall = 0; branch_taken = 0;
        repeat (3) tick();

        redirect(1, 0, 0, 8'h33);
        tick();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #3 reset = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 3000; i++) begin
            stall = $urandom_range(0, 4) == 0;
            branch_taken = $urandom_range(0, 9) == 0;
            call = $urandom_range(0, 6) == 0;
            ret = $urandom_range(0, 6) == 0;
            branch_target = 8'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/limb_fetch.md
Name: limb_fetch

Overview:
- Instruction fetch stage of the Limb CPU; sits directly upstream of the decoder.
- Owns the program counter and drives the program ROM address.
- Latches the returned 32-bit instruction word into the instruction register, then presents it to the decoder with its address and a valid flag.
- Handles branch, call and return redirects using an internal hardware call stack of return addresses; this stack is not user-visible.

Parameters:
- PC_W, 8: program counter and ROM address width.
- IR_W, 32: instruction word width.
- STACK_DEPTH, 16: number of call-stack entries; must be a power of two.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold all state this cycle.
- rom_addr  out  PC_W  program ROM address; combinational copy of pc.
- rom_data  in  IR_W  ROM read data; combinational, valid in the same cycle.
- ir  out  IR_W  latched instruction, to the decoder.
- ir_pc  out  PC_W  address the current ir was fetched from.
- ir_valid  out  1  ir holds a live instruction.
- branch_taken  in  1  redirect to branch_target.
- call  in  1  push ir_pc+1 onto the call stack, then redirect to branch_target.
- ret  in  1  pop the call stack and redirect to the popped address.
- branch_target  in  PC_W  target address for branch and call.
- sp  out  $clog2(STACK_DEPTH)+1  current call-stack occupancy.
- stack_overflow  out  1  sticky; a call was made while the stack was full.
- stack_underflow  out  1  sticky; a ret was made while the stack was empty.

Behaviour:
- Reset values (applied asynchronously):
  - pc = 0, ir = 0, ir_pc = 0, ir_valid = 0.
  - sp = 0, stack_overflow = 0, stack_underflow = 0.
  - Stack entry contents are not reset.
- Reset asserted mid-operation aborts any redirect in progress and discards the stack contents.
- Fetch latency is 1 cycle. Sequential (non-stalled) cycle:
  - ir <= rom_data, ir_pc <= pc, ir_valid <= 1.
  - pc <= pc+1, wrapping modulo 2^PC_W (255 -> 0).
- First cycle after reset release: ir = rom[0], ir_pc = 0, ir_valid = 1, pc = 1.
- Redirect inputs (ret, call, branch_taken) are qualified by ir_valid=1 and stall=0; otherwise they are ignored.
- Priority per cycle: reset > stall > ret > call > branch_taken > sequential.
- stall=1: pc, ir, ir_pc, ir_valid, stack, sp and flags all hold; the ROM address stays stable.
- Any redirect:
  - pc <= target.
  - ir_valid <= 0, flushing the wrong-path word.
  - Exactly one bubble; the target instruction appears in ir two edges after the redirect edge.
- Call, stack not full: stack[sp] <= ir_pc+1 (wrapping), sp <= sp+1, pc <= branch_target.
- Call, stack full (sp = STACK_DEPTH): no push, sp unchanged, stack_overflow <= 1; the jump still occurs.
- Ret, stack not empty: pc <= stack[sp-1], sp <= sp-1.
- Ret, stack empty (sp = 0): sp unchanged, stack_underflow <= 1, pc <= ir_pc+1 (falls through); a bubble is still inserted.
- Simultaneous call and ret: ret wins and no push occurs.
- Sticky flags clear only on reset.

Decomposition:
- Shared package limb_pkg holds:
  - constants PC_W = 8 and IR_W = 32;
  - enum redirect_e {RD_NONE, RD_BRANCH, RD_CALL, RD_RET} used for the priority encode.
- One sub-module, limb_call_stack, parameterised by STACK_DEPTH and PC_W.
  - Inputs: push, pop, din.
  - Outputs: dout (combinational top entry), sp, full, empty.
  - Includes overflow/underflow protection.
- limb_fetch owns the pc/ir registers, redirect priority and sticky flags.

Test Plan:
- Reset release with ROM word N = 0x1000_0000+N, no redirects:
  - ir sequence is 0x1000_0000, 0x1000_0001, ...; ir_pc = 0, 1, ...
  - After 256 fetches, ir_pc wraps 255 -> 0.
- branch_taken with target 0x40 while ir_pc = 0x05:
  - Next cycle ir_valid = 0.
  - Following cycle ir = rom[0x40], ir_pc = 0x40.
- Call to 0x80 from ir_pc = 0x10, then ret at 0x82:
  - sp goes 0 -> 1 -> 0.
  - After the ret bubble, ir_pc = 0x11.
- 17 nested calls with STACK_DEPTH = 16:
  - sp saturates at 16; stack_overflow = 1 after the 17th call; the 17th jump is taken.
  - 16 rets return to correct addresses in LIFO order; a 17th ret sets stack_underflow = 1 and falls through to ir_pc+1.
- stall held 3 cycles with branch_taken asserted:
  - pc, ir and sp are unchanged throughout; no redirect occurs.
  - Sequential fetch resumes on release.
- Assert reset asynchronously mid-call, one cycle after the push:
  - All outputs go to their reset values immediately, sp = 0, flags = 0.
  - After release, fetch restarts at address 0.
